dpram_stream_out: RTL and testbench

DPRAM_STREAM_OUT -- requirements
Module: dpram_stream_out

---
 rtl/dpram_stream_out.sv | 192 +++++++++++++++++++
 tb/tb_dpram_stream_out.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_out.sv
// Drains a DPRAM buffer through its read port into a valid/ready word stream.
// Reads are paced so a 2-entry skid FIFO absorbs the one-cycle RAM latency without overflow.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for dpram_run
//   STREAM | issuing reads and emitting words until the last word pops
//   FINISH | last word popped; pulse dpram_done, a new run may be accepted
module dpram_stream_out #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dpram_run,
  input  logic [15:0]       dpram_len,
  output logic              dpram_busy,
  output logic              dpram_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  input  logic              clr_err,
  output logic              len_err,
  output logic              run_err
);

  localparam int          LEN_W   = ADDR_W + 1;
  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]    send_cnt_q, send_cnt_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                zero_pend_q, zero_pend_d;
  logic                len_err_q, len_err_d;
  logic                run_err_q, run_err_d;
  logic [DATA_W-1:0]   fifo_mem_q [2];
  logic [DATA_W-1:0]   fifo_mem_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  logic                pop;
  logic                issue;
  logic                head_is_last;
  logic                can_start;
  logic                len_over;
  logic [31:0]         req_len;
  logic [2:0]          occ;

  assign m_valid      = (count_q != 2'd0);
  assign m_data       = fifo_mem_q[rd_ptr_q];
  assign pop          = m_valid && m_ready;
  assign head_is_last = (send_cnt_q == (len_q - LEN_W'(1)));
  assign m_last       = m_valid && head_is_last;

  // Slots already committed: words held plus the read whose data lands next edge.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == S_STREAM) && (issue_cnt_q < len_q) && (occ < 3'd2);

  assign rd_en   = issue;
  assign rd_addr = issue ? issue_cnt_q[ADDR_W-1:0] : last_addr_q;

  assign req_len   = 32'(dpram_len);
  assign len_over  = (req_len > MAX_LEN);
  assign can_start = (state_q == S_IDLE) || (state_q == S_FINISH);

  assign dpram_busy = busy_q;
  assign dpram_done = done_q;
  assign len_err    = len_err_q;
  assign run_err    = run_err_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    send_cnt_d  = send_cnt_q;
    last_addr_d = last_addr_q;
    inflight_d  = issue;
    busy_d      = (state_q == S_STREAM);
    done_d      = zero_pend_q;
    zero_pend_d = 1'b0;
    len_err_d   = clr_err ? 1'b0 : len_err_q;
    run_err_d   = clr_err ? 1'b0 : run_err_q;

    if (issue) begin
      issue_cnt_d = issue_cnt_q + LEN_W'(1);
      last_addr_d = issue_cnt_q[ADDR_W-1:0];
    end
    if (pop) begin
      send_cnt_d = send_cnt_q + LEN_W'(1);
    end

    case (state_q)
      S_IDLE: ;
      S_STREAM: begin
        if (pop && head_is_last) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (dpram_run) begin
      if (!can_start) begin
        run_err_d = 1'b1;
      end else if (dpram_len == 16'd0) begin
        zero_pend_d = 1'b1;
      end else begin
        state_d     = S_STREAM;
        len_d       = len_over ? MAX_LEN[LEN_W-1:0] : req_len[LEN_W-1:0];
        issue_cnt_d = '0;
        send_cnt_d  = '0;
        if (len_over) begin
          len_err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (inflight_q) begin
      fifo_mem_d[wr_ptr_q] = rd_data;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      send_cnt_q    <= '0;
      inflight_q    <= 1'b0;
      last_addr_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      zero_pend_q   <= 1'b0;
      len_err_q     <= 1'b0;
      run_err_q     <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
      send_cnt_q    <= send_cnt_d;
      inflight_q    <= inflight_d;
      last_addr_q   <= last_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      zero_pend_q   <= zero_pend_d;
      len_err_q     <= len_err_d;
      run_err_q     <= run_err_d;
      fifo_mem_q[0] <= fifo_mem_d[0];
      fifo_mem_q[1] <= fifo_mem_d[1];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_dpram_stream_out.sv
// Bench for dpram_stream_out: synchronous RAM model, word scoreboard, cycle-exact and random drains.
module tb_dpram_stream_out;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dpram_run = 1'b0;
  logic [15:0]       dpram_len = '0;
  logic              dpram_busy, dpram_done;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_last;
  logic              m_ready = 1'b1;
  logic              clr_err = 1'b0;
  logic              len_err, run_err;

  dpram_stream_out #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .dpram_run(dpram_run), .dpram_len(dpram_len),
    .dpram_busy(dpram_busy), .dpram_done(dpram_done), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .clr_err(clr_err), .len_err(len_err), .run_err(run_err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_pop    = 0;
  bit rand_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [DATA_W:0]   exp_q [$];
  int                addr_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected stream of a drain: words 0..n-1 of the buffer, last flag on the final one.
  task automatic push_expected(input int len);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mem[i]});
  endtask

  task automatic start_run(input int len);
    @(posedge clk); #1;
    dpram_run = 1'b1;
    dpram_len = 16'(len);
    @(posedge clk); #1;
    dpram_run = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (dpram_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  initial forever begin
    @(posedge clk); #1;
    m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Stream monitor: scoreboard on every pop, stall stability, done and issued-address logging.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("last_needs_valid", m_last & ~m_valid, 0);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [DATA_W:0] e;
          e = exp_q.pop_front();
          check("word_data", m_data, e[DATA_W-1:0]);
          check("word_last", m_last, e[DATA_W]);
        end
        n_pop++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (dpram_done) n_done++;
      if (rd_en) addr_log.push_back(int'(rd_addr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i + 'h100);
    #3;
    check("rst_busy", dpram_busy, 0);
    check("rst_done", dpram_done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_errs", {len_err, run_err}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Cycle-exact drain of 10 words with m_ready held high.
    n_done = 0;
    push_expected(10);
    start_run(10);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("t1_busy", dpram_busy, (k >= 1 && k <= 12));
      check("t1_done", dpram_done, (k == 13));
      check("t1_valid", m_valid, (k >= 2 && k <= 11));
      if (k >= 2 && k <= 11) begin
        check("t1_data", m_data, 'h100 + k - 2);
        check("t1_last", m_last, (k == 11));
      end
      check("t1_rd_en", rd_en, (k <= 9));
      check("t1_rd_addr", rd_addr, (k <= 9) ? k : 9);
    end
    check("t1_done_count", n_done, 1);

    // Random buffer contents and 50% backpressure.
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    rand_ready = 1'b1;
    for (int it = 0; it < 7; it++) begin
      int len;
      len = (it == 0) ? 8 : (it == 1) ? 1 : int'($urandom_range(2, 40));
      n_done = 0;
      push_expected(len);
      start_run(len);
      wait_done(20 * len + 50, "t2");
      repeat (4) @(negedge clk);
      check("t2_done_count", n_done, 1);
      check("t2_all_words", exp_q.size(), 0);
    end
    rand_ready = 1'b0;

    // Zero length, then an over-long length clamped to the buffer size.
    n_done = 0;
    start_run(0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_zero_done", dpram_done, (k == 1));
      check("t3_zero_busy", dpram_busy, 0);
      check("t3_zero_valid", m_valid, 0);
    end
    check("t3_zero_len_err", len_err, 0);
    push_expected(3000);
    start_run(3000);
    @(negedge clk);
    check("t3_len_err", len_err, 1);
    wait_done(DEPTH + 100, "t3");
    repeat (3) @(negedge clk);
    check("t3_done_count", n_done, 2);
    check("t3_all_words", exp_q.size(), 0);
    pulse_clr();
    @(negedge clk);
    check("t3_len_err_clr", len_err, 0);

    // Second run during a drain, coinciding with clr_err: error wins, drain intact.
    n_done = 0;
    push_expected(20);
    start_run(20);
    repeat (5) @(negedge clk);
    check("t4_run_err_pre", run_err, 0);
    @(posedge clk); #1;
    dpram_run = 1'b1; dpram_len = 16'd4; clr_err = 1'b1;
    @(posedge clk); #1;
    dpram_run = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    check("t4_run_err", run_err, 1);
    wait_done(100, "t4");
    repeat (3) @(negedge clk);
    check("t4_done_count", n_done, 1);
    check("t4_all_words", exp_q.size(), 0);
    pulse_clr();
    @(negedge clk);
    check("t4_run_err_clr", run_err, 0);

    // Run presented in the FINISH cycle is accepted without run_err.
    n_done = 0;
    push_expected(6);
    start_run(6);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (m_valid && m_ready && m_last) begin
          seen = 1'b1;
          break;
        end
      end
      check("t4_last_seen", seen, 1);
    end
    @(posedge clk); #1;
    dpram_run = 1'b1; dpram_len = 16'd5;
    push_expected(5);
    @(posedge clk); #1;
    dpram_run = 1'b0;
    @(negedge clk);
    check("t4_fin_done", dpram_done, 1);
    check("t4_fin_busy_low", dpram_busy, 0);
    @(negedge clk);
    check("t4_fin_busy_back", dpram_busy, 1);
    wait_done(100, "t4_fin");
    repeat (3) @(negedge clk);
    check("t4_fin_done_count", n_done, 2);
    check("t4_fin_run_err", run_err, 0);
    check("t4_fin_all_words", exp_q.size(), 0);

    // Reset after 4 of 10 words, then a fresh 5-word drain from address 0.
    n_done = 0;
    n_pop  = 0;
    push_expected(10);
    start_run(10);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk);
        if (n_pop >= 4) begin
          seen = 1'b1;
          break;
        end
      end
      check("t5_four_popped", seen, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", dpram_busy, 0);
    check("t5_rst_done", dpram_done, 0);
    check("t5_rst_rd_en", rd_en, 0);
    check("t5_rst_rd_addr", rd_addr, 0);
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_last", m_last, 0);
    check("t5_rst_data", m_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t5_no_done", n_done, 0);
    addr_log.delete();
    push_expected(5);
    start_run(5);
    wait_done(100, "t5");
    repeat (3) @(negedge clk);
    check("t5_addr_count", addr_log.size(), 5);
    for (int i = 0; i < addr_log.size() && i < 5; i++) check("t5_addr", addr_log[i], i);
    check("t5_done_count", n_done, 1);
    check("t5_all_words", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
